// File: rtl/psum_accum_if.sv
`default_nettype none
// ============================================================================
// psum_accum_if : control, beat, partial-sum memory and result-stream bundle
//                 for the partial-sum accumulator.
// Revision      : 1.0
// ============================================================================
interface psum_accum_if #(
  parameter int DataWidth = 16,
  parameter int Lanes     = 4,
  parameter int AddrWidth = 16
);
  localparam int Width = DataWidth * Lanes;

  logic                 start;
  logic [1:0]           mode;
  logic [AddrWidth-1:0] pix_count;
  logic                 relu_en;

  logic                 in_valid;
  logic [Width-1:0]     in_data;
  logic                 in_ready;

  logic                 rd_en;
  logic [AddrWidth-1:0] rd_addr;
  logic [Width-1:0]     rd_data;

  logic                 wr_en;
  logic [AddrWidth-1:0] wr_addr;
  logic [Width-1:0]     wr_data;

  logic                 out_valid;
  logic [Width-1:0]     out_data;

  logic                 busy;
  logic                 done;
  logic                 sat_flag;

  modport master (
    output start, mode, pix_count, relu_en, in_valid, in_data, rd_data,
    input  in_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data,
           out_valid, out_data, busy, done, sat_flag
  );

  modport slave (
    input  start, mode, pix_count, relu_en, in_valid, in_data, rd_data,
    output in_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data,
           out_valid, out_data, busy, done, sat_flag
  );
endinterface
`default_nettype wire

// File: rtl/psum_accum.sv
`default_nettype none
// ============================================================================
// psum_accum : per-lane saturating partial-sum accumulator with fixed
//              RdLatency+1 pipeline, memory write-back or result streaming.
// Revision   : 1.0
// ============================================================================
module psum_accum #(
  parameter int DataWidth = 16,
  parameter int Lanes     = 4,
  parameter int AddrWidth = 16,
  parameter int RdLatency = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  psum_accum_if.slave bus
);
  localparam int c_width = DataWidth * Lanes;

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  localparam logic [1:0] c_mode_accum = 2'd1;
  localparam logic [1:0] c_mode_last  = 2'd2;

  localparam logic [DataWidth-1:0] c_sat_max = {1'b0, {(DataWidth-1){1'b1}}};
  localparam logic [DataWidth-1:0] c_sat_min = {1'b1, {(DataWidth-1){1'b0}}};
  localparam logic [AddrWidth-1:0] c_addr_one = {{(AddrWidth-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [1:0]           r_mode;
  logic                 r_relu;
  logic [AddrWidth-1:0] r_count;
  logic [AddrWidth-1:0] r_fore;
  logic [AddrWidth-1:0] r_back;
  logic                 r_sat;

  logic                 r_pv [RdLatency];
  logic [c_width-1:0]   r_pd [RdLatency];

  logic                 r_wr_en;
  logic                 r_out_valid;
  logic [c_width-1:0]   r_wr_data;
  logic [c_width-1:0]   r_out_data;

  logic                 w_run;
  logic                 w_accept;
  logic                 w_use_rd;
  logic                 w_stream;
  logic                 w_rd;
  logic                 w_stage_v;
  logic                 w_vis;
  logic                 w_sat_any;
  logic [c_width-1:0]   w_sum;
  logic [c_width-1:0]   w_relu;
  logic [DataWidth-1:0] w_op;
  logic [DataWidth-1:0] w_in;
  logic [DataWidth:0]   w_ext;
  logic [DataWidth-1:0] w_lane;

  assign w_run     = (r_state == c_run);
  assign w_accept  = bus.in_valid & w_run;
  assign w_use_rd  = (r_mode == c_mode_accum) || (r_mode == c_mode_last);
  assign w_stream  = r_mode[1];
  assign w_rd      = w_accept & w_use_rd;
  assign w_stage_v = r_pv[RdLatency-1];
  assign w_vis     = r_wr_en | r_out_valid;

  // Lane sums are formed one bit wider; differing top bits mean overflow.
  always_comb begin
    w_sum     = '0;
    w_relu    = '0;
    w_sat_any = 1'b0;
    w_op      = '0;
    w_in      = '0;
    w_ext     = '0;
    w_lane    = '0;
    for (int i = 0; i < Lanes; i++) begin
      w_op  = w_use_rd ? bus.rd_data[i*DataWidth +: DataWidth] : '0;
      w_in  = r_pd[RdLatency-1][i*DataWidth +: DataWidth];
      w_ext = {w_op[DataWidth-1], w_op} + {w_in[DataWidth-1], w_in};
      if (w_ext[DataWidth] != w_ext[DataWidth-1]) begin
        w_sat_any = 1'b1;
        w_lane    = w_ext[DataWidth] ? c_sat_min : c_sat_max;
      end else begin
        w_lane    = w_ext[DataWidth-1:0];
      end
      w_sum[i*DataWidth +: DataWidth]  = w_lane;
      w_relu[i*DataWidth +: DataWidth] = w_lane[DataWidth-1] ? '0 : w_lane;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= c_idle;
      r_mode      <= '0;
      r_relu      <= 1'b0;
      r_count     <= '0;
      r_fore      <= '0;
      r_back      <= '0;
      r_sat       <= 1'b0;
      r_wr_en     <= 1'b0;
      r_out_valid <= 1'b0;
      r_wr_data   <= '0;
      r_out_data  <= '0;
      for (int s = 0; s < RdLatency; s++) begin
        r_pv[s] <= 1'b0;
        r_pd[s] <= '0;
      end
    end else begin
      r_pv[0] <= w_accept;
      r_pd[0] <= bus.in_data;
      for (int s = 1; s < RdLatency; s++) begin
        r_pv[s] <= r_pv[s-1];
        r_pd[s] <= r_pd[s-1];
      end

      r_wr_en     <= w_stage_v & ~w_stream;
      r_out_valid <= w_stage_v & w_stream;
      r_wr_data   <= (w_stage_v & ~w_stream) ? w_sum : '0;
      r_out_data  <= (w_stage_v & w_stream) ? (r_relu ? w_relu : w_sum) : '0;

      if (w_stage_v && w_sat_any) begin
        r_sat <= 1'b1;
      end
      if (w_vis) begin
        r_back <= r_back + c_addr_one;
      end

      case (r_state)
        c_idle: begin
          if (bus.start) begin
            r_mode  <= bus.mode;
            r_count <= bus.pix_count;
            r_relu  <= bus.relu_en;
            r_fore  <= '0;
            r_back  <= '0;
            r_sat   <= 1'b0;
            r_state <= (bus.pix_count == '0) ? c_done : c_run;
          end
        end
        c_run: begin
          if (w_accept) begin
            r_fore <= r_fore + c_addr_one;
            if ((r_fore + c_addr_one) == r_count) begin
              r_state <= c_drain;
            end
          end
        end
        c_drain: begin
          // The last completion is the one currently on the write/stream port.
          if (w_vis && ((r_back + c_addr_one) == r_count)) begin
            r_state <= c_done;
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_run;
  assign bus.rd_en     = w_rd;
  assign bus.rd_addr   = w_rd ? r_fore : '0;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_en ? r_back : '0;
  assign bus.wr_data   = r_wr_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = (r_state == c_run) || (r_state == c_drain);
  assign bus.done      = (r_state == c_done);
  assign bus.sat_flag  = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_psum_accum.sv
`default_nettype none
// Bench for psum_accum: random and directed passes checked every cycle against
// a timeline model (beat accepted at cycle t -> result at t+RdLatency+1).
module tb_psum_accum;
  localparam int DW   = 16;
  localparam int LN   = 4;
  localparam int AW   = 16;
  localparam int RDL  = 1;
  localparam int LAT  = RDL + 1;
  localparam int W    = DW * LN;
  localparam int MAXC = 16384;
  localparam int INF  = 1 << 30;
  localparam int SMAX = (1 << (DW - 1)) - 1;
  localparam int SMIN = -(1 << (DW - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psum_accum_if #(.DataWidth(DW), .Lanes(LN), .AddrWidth(AW)) bus ();
  psum_accum #(.DataWidth(DW), .Lanes(LN), .AddrWidth(AW), .RdLatency(RDL)) dut (
    .Clk(clk), .Rst(rst), .bus(bus)
  );

  // Partial-sum memory seen by the DUT
  logic [W-1:0] mem [256];
  logic [W-1:0] rd_pipe [RDL];
  always @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr[7:0]] <= bus.wr_data;
    rd_pipe[0] <= mem[bus.rd_addr[7:0]];
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.rd_data = rd_pipe[RDL-1];

  // Per-cycle expectations
  bit           e_in_ready [MAXC];
  bit           e_rd_en    [MAXC];
  bit [AW-1:0]  e_rd_addr  [MAXC];
  bit           e_wr_en    [MAXC];
  bit [AW-1:0]  e_wr_addr  [MAXC];
  bit [W-1:0]   e_wr_data  [MAXC];
  bit           e_out_valid[MAXC];
  bit [W-1:0]   e_out_data [MAXC];
  bit           e_busy     [MAXC];
  bit           e_done     [MAXC];
  bit           e_sat      [MAXC];
  bit [W-1:0]   ref_mem    [256];

  int  cyc = 0;
  bit  chk_en = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  bit       m_active = 0;
  bit [1:0] m_mode = 0;
  bit       m_relu = 0;
  int       m_cnt = 0;
  int       m_acc = 0;
  bit       m_sat = 0;
  int       sat_at = INF;
  int       done_at = -1;
  int       last_vis = -1;

  logic [W-1:0] beatq[$];
  bit           gapq[$];

  typedef struct {int c; bit wr; int addr; int l0;} ev_t;
  ev_t log_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input int v);
    logic [W-1:0] w;
    for (int i = 0; i < LN; i++) w[i*DW +: DW] = v[DW-1:0];
    return w;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    int v;
    for (int i = 0; i < LN; i++) begin
      if ($urandom_range(3) == 0) v = int'($urandom_range(65535));
      else v = int'($urandom_range(400)) - 200;
      w[i*DW +: DW] = v[DW-1:0];
    end
    return w;
  endfunction

  // Plain integer add-and-clamp per lane
  function automatic void lane_math(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] sum, output logic [W-1:0] rl,
                                    output bit sat);
    int x;
    sum = '0; rl = '0; sat = 0;
    for (int i = 0; i < LN; i++) begin
      x = int'($signed(a[i*DW +: DW])) + int'($signed(b[i*DW +: DW]));
      if (x > SMAX) begin x = SMAX; sat = 1; end
      else if (x < SMIN) begin x = SMIN; sat = 1; end
      sum[i*DW +: DW] = x[DW-1:0];
      rl[i*DW +: DW]  = (x < 0) ? '0 : x[DW-1:0];
    end
  endfunction

  task automatic model_cycle();
    int c;
    int k;
    logic [W-1:0] op, s_raw, s_rl;
    bit s_sat;
    c = cyc;
    if (e_wr_en[c]) ref_mem[e_wr_addr[c][7:0]] = e_wr_data[c];
    if (sat_at <= c) m_sat = 1;
    e_sat[c]      = m_sat;
    e_busy[c]     = m_active;
    e_in_ready[c] = m_active && (m_acc < m_cnt);
    e_done[c]     = (c == done_at);
    if (rst) begin
      for (int i = 1; i <= LAT; i++) begin
        e_wr_en[c+i] = 0;
        e_out_valid[c+i] = 0;
      end
      m_active = 0; m_acc = 0; m_sat = 0; sat_at = INF; done_at = -1; last_vis = -1;
    end else begin
      if (e_in_ready[c] && bus.in_valid) begin
        k = m_acc;
        e_rd_en[c]   = (m_mode == 2'd1) || (m_mode == 2'd2);
        e_rd_addr[c] = k[AW-1:0];
        op = e_rd_en[c] ? ref_mem[k[7:0]] : '0;
        lane_math(op, bus.in_data, s_raw, s_rl, s_sat);
        if (m_mode < 2) begin
          e_wr_en[c+LAT] = 1; e_wr_addr[c+LAT] = k[AW-1:0]; e_wr_data[c+LAT] = s_raw;
        end else begin
          e_out_valid[c+LAT] = 1; e_out_data[c+LAT] = m_relu ? s_rl : s_raw;
        end
        if (s_sat && sat_at > c + LAT) sat_at = c + LAT;
        m_acc++;
        if (m_acc == m_cnt) begin
          last_vis = c + LAT;
          done_at  = c + LAT + 1;
        end
      end
      if (m_active && c == last_vis) m_active = 0;
      if (!e_busy[c] && c != done_at && bus.start) begin
        m_mode = bus.mode; m_relu = bus.relu_en; m_cnt = int'(bus.pix_count);
        m_acc = 0; m_sat = 0; sat_at = INF; last_vis = -1;
        if (m_cnt == 0) done_at = c + 1;
        else begin m_active = 1; done_at = -1; end
      end
    end
  endtask

  task automatic drive(input bit st, input bit [1:0] md, input int pc, input bit re,
                       input bit iv, input logic [W-1:0] d, input bit rs);
    @(posedge clk); #1;
    cyc++;
    bus.start = st; bus.mode = md; bus.pix_count = pc[AW-1:0]; bus.relu_en = re;
    bus.in_valid = iv; bus.in_data = d; rst = rs;
    model_cycle();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  W'(bus.in_ready),  W'(e_in_ready[cyc]));
      check("rd_en",     W'(bus.rd_en),     W'(e_rd_en[cyc]));
      if (e_rd_en[cyc]) check("rd_addr", W'(bus.rd_addr), W'(e_rd_addr[cyc]));
      check("wr_en",     W'(bus.wr_en),     W'(e_wr_en[cyc]));
      if (e_wr_en[cyc]) begin
        check("wr_addr", W'(bus.wr_addr), W'(e_wr_addr[cyc]));
        check("wr_data", bus.wr_data, e_wr_data[cyc]);
      end
      check("out_valid", W'(bus.out_valid), W'(e_out_valid[cyc]));
      if (e_out_valid[cyc]) check("out_data", bus.out_data, e_out_data[cyc]);
      check("busy",      W'(bus.busy),      W'(e_busy[cyc]));
      check("done",      W'(bus.done),      W'(e_done[cyc]));
      check("sat_flag",  W'(bus.sat_flag),  W'(e_sat[cyc]));
    end
  end

  always @(negedge clk) begin
    if (chk_en && (bus.wr_en || bus.out_valid))
      log_q.push_back('{cyc, bus.wr_en, int'(bus.wr_addr),
                        bus.wr_en ? int'($signed(bus.wr_data[DW-1:0]))
                                  : int'($signed(bus.out_data[DW-1:0]))});
  end

  function automatic int ev_l0(input int i);
    return (i < log_q.size()) ? log_q[i].l0 : -999999;
  endfunction
  function automatic int ev_addr(input int i);
    return (i < log_q.size()) ? log_q[i].addr : -1;
  endfunction
  function automatic int ev_c(input int i);
    return (i < log_q.size()) ? log_q[i].c : -1;
  endfunction
  function automatic int ev_wr(input int i);
    return (i < log_q.size()) ? int'(log_q[i].wr) : -1;
  endfunction

  // Runs one pass from IDLE; rst_at / busy_start_at count cycles after start (-1 = never)
  task automatic run_pass(input bit [1:0] md, input int pc, input bit re, input int gap_pct,
                          input int rst_at, input int busy_start_at);
    int n;
    bit want, iv, st;
    logic [W-1:0] d;
    drive(1'b1, md, pc, re, 1'b0, rnd_word(), 1'b0);
    n = 0;
    while (!(done_at >= 0 && cyc >= done_at)) begin
      n++;
      if (n > 2000) begin
        check_int("pass_timeout", n, 0);
        return;
      end
      if (n == rst_at) begin
        drive(1'b0, 2'($urandom_range(3)), 5, 1'b0, 1'b0, rnd_word(), 1'b1);
        drive(1'b0, 2'd0, 0, 1'b0, 1'b0, '0, 1'b0);
        return;
      end
      want = m_active && (m_acc < m_cnt);
      d = rnd_word();
      if (want) begin
        if (gapq.size() > 0) iv = gapq.pop_front();
        else iv = (int'($urandom_range(99)) >= gap_pct);
        if (iv && beatq.size() > 0) d = beatq.pop_front();
      end else begin
        iv = ($urandom_range(2) == 0);
      end
      st = (n == busy_start_at);
      drive(st, 2'($urandom_range(3)), int'($urandom_range(1, 9)), 1'($urandom_range(1)),
            iv, d, 1'b0);
    end
  endtask

  initial begin
    int base;
    int s;
    bus.start = 0; bus.mode = 0; bus.pix_count = 0; bus.relu_en = 0;
    bus.in_valid = 0; bus.in_data = '0;
    drive(0, 0, 0, 0, 0, '0, 1);
    drive(0, 0, 0, 0, 0, '0, 1);
    chk_en = 1;
    drive(0, 0, 0, 0, 0, '0, 1);
    drive(0, 0, 0, 0, 0, '0, 0);

    // FIRST, three back-to-back beats
    base = log_q.size(); s = cyc + 1;
    beatq = '{rep(5), rep(6), rep(7)};
    run_pass(2'd0, 3, 0, 0, -1, -1);
    for (int i = 0; i < 3; i++) begin
      check_int("first_addr", ev_addr(base + i), i);
      check_int("first_data", ev_l0(base + i), 5 + i);
      check_int("first_latency", ev_c(base + i) - s, 3 + i);
    end
    check_int("first_done_cycle", done_at - s, 6);

    // ACCUM over memory of 10 with a gap after beat 2
    beatq = '{rep(10), rep(10), rep(10), rep(10)};
    run_pass(2'd0, 4, 0, 0, -1, -1);
    base = log_q.size();
    beatq = '{rep(1), rep(2), rep(3), rep(4)}; gapq = '{1, 1, 0, 1, 1};
    run_pass(2'd1, 4, 0, 0, -1, -1);
    for (int i = 0; i < 4; i++) begin
      check_int("accum_addr", ev_addr(base + i), i);
      check_int("accum_data", ev_l0(base + i), 11 + i);
    end
    check_int("accum_gap", ev_c(base + 2) - ev_c(base + 1), 2);

    // LAST with ReLU over memory of -8
    beatq = '{rep(-8), rep(-8)};
    run_pass(2'd0, 2, 0, 0, -1, -1);
    base = log_q.size();
    beatq = '{rep(3), rep(20)};
    run_pass(2'd2, 2, 1, 0, -1, -1);
    check_int("last_relu_lane0", ev_l0(base), 0);
    check_int("last_lane0", ev_l0(base + 1), 12);
    check_int("last_is_stream", ev_wr(base), 0);

    // Positive saturation, sticky until the next start
    beatq = '{rep(32000)};
    run_pass(2'd0, 1, 0, 0, -1, -1);
    base = log_q.size();
    beatq = '{rep(1000)};
    run_pass(2'd1, 1, 0, 0, -1, -1);
    check_int("sat_data", ev_l0(base), 32767);
    drive(0, 0, 0, 0, 0, '0, 0);
    check_int("sat_sticky", int'(bus.sat_flag), 1);
    beatq = '{rep(1)};
    run_pass(2'd0, 1, 0, 0, -1, -1);
    check_int("sat_cleared", int'(bus.sat_flag), 0);

    // Zero-length pass and start while busy
    base = log_q.size(); s = cyc + 1;
    run_pass(2'd1, 0, 0, 0, -1, -1);
    check_int("zero_len_done", done_at - s, 1);
    check_int("zero_len_writes", log_q.size() - base, 0);
    run_pass(2'd0, 5, 0, 20, -1, 2);
    check_int("busy_start_writes", log_q.size() - base, 5);

    // Reset two cycles into an 8-beat pass
    base = log_q.size();
    run_pass(2'd0, 8, 0, 0, 2, -1);
    repeat (4) drive(0, 0, 0, 0, 0, '0, 0);
    check_int("abort_no_writes", log_q.size() - base, 0);
    beatq = '{rep(9), rep(9)};
    run_pass(2'd0, 2, 0, 0, -1, -1);
    check_int("restart_addr0", ev_addr(base), 0);
    check_int("restart_addr1", ev_addr(base + 1), 1);

    // Random passes over an initialised memory region
    run_pass(2'd0, 64, 0, 10, -1, -1);
    for (int p = 0; p < 30; p++) begin
      run_pass(2'($urandom_range(3)),
               ($urandom_range(19) == 0) ? 0 : int'($urandom_range(1, 64)),
               1'($urandom_range(1)), int'($urandom_range(60)), -1,
               ($urandom_range(3) == 0) ? int'($urandom_range(1, 6)) : -1);
      if ($urandom_range(9) == 0) run_pass(2'($urandom_range(3)), 6, 0, 0, 3, -1);
    end
    repeat (3) drive(0, 0, 0, 0, 0, '0, 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
